// File: rtl/tick_debouncer_pkg.sv
// Shared timer/counter constants: debouncer FSM state encoding and the
// upstream tick counter's overflow period.
package tick_debouncer_pkg;

  localparam logic [1:0] ST_STABLE_LOW  = 2'b00;
  localparam logic [1:0] ST_PEND_HIGH   = 2'b01;
  localparam logic [1:0] ST_STABLE_HIGH = 2'b11;
  localparam logic [1:0] ST_PEND_LOW    = 2'b10;

  localparam int TICK_DIV   = 26;
  localparam int TICK_CNT_W = $clog2(TICK_DIV);

  // Counter width able to hold 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tick_debouncer_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr_p0 = {STAGES{RST_VAL}};

  always_ff @(posedge clk) begin
    if (rst) sr_p0 <= {STAGES{RST_VAL}};
    else     sr_p0 <= {sr_p0[STAGES-2:0], d};
  end

  assign q = sr_p0[STAGES-1];

endmodule

// File: rtl/tick_debouncer.sv
// Tick-sampled debouncer: a level change commits only after STABLE_TICKS
// consecutive agreeing tick samples; emits one-cycle rise/fall pulses.
module tick_debouncer
  import tick_debouncer_pkg::*;
#(
  parameter int STABLE_TICKS = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int            CW       = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS);

  logic          samp;
  logic [1:0]    state_p1 = ST_STABLE_LOW;
  logic [CW-1:0] cnt_p1   = '0;
  logic          dout_p1  = 1'b0;
  logic          rise_p1  = 1'b0;
  logic          fall_p1  = 1'b0;
  logic [CW-1:0] cnt_inc;

  // Stage 0: synchronise the raw contact input
  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (samp)
  );

  // cnt is zero in both stable states, so the same increment serves the
  // first disagreeing sample (and commits directly when STABLE_TICKS=1).
  assign cnt_inc = cnt_p1 + 1'b1;

  // Stage 1: tick-qualified FSM, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= ST_STABLE_LOW;
      cnt_p1   <= '0;
      dout_p1  <= 1'b0;
      rise_p1  <= 1'b0;
      fall_p1  <= 1'b0;
    end else begin
      rise_p1 <= 1'b0;
      fall_p1 <= 1'b0;
      if (tick) begin
        case (state_p1)
          ST_STABLE_LOW, ST_PEND_HIGH: begin
            if (samp) begin
              if (cnt_inc == CNT_LAST) begin
                state_p1 <= ST_STABLE_HIGH;
                cnt_p1   <= '0;
                dout_p1  <= 1'b1;
                rise_p1  <= 1'b1;
              end else begin
                state_p1 <= ST_PEND_HIGH;
                cnt_p1   <= cnt_inc;
              end
            end else begin
              state_p1 <= ST_STABLE_LOW;
              cnt_p1   <= '0;
            end
          end
          default: begin
            if (!samp) begin
              if (cnt_inc == CNT_LAST) begin
                state_p1 <= ST_STABLE_LOW;
                cnt_p1   <= '0;
                dout_p1  <= 1'b0;
                fall_p1  <= 1'b1;
              end else begin
                state_p1 <= ST_PEND_LOW;
                cnt_p1   <= cnt_inc;
              end
            end else begin
              state_p1 <= ST_STABLE_HIGH;
              cnt_p1   <= '0;
            end
          end
        endcase
      end
    end
  end

  assign dout = dout_p1;
  assign rise = rise_p1;
  assign fall = fall_p1;
  assign busy = (state_p1 == ST_PEND_HIGH) || (state_p1 == ST_PEND_LOW);

endmodule
